pueo_pps_sec_core: RTL and testbench

PUEO_PPS_SEC_CORE -- requirements
Module: pueo_pps_sec_core

---
 rtl/pueo_pps_sec_core.sv | 135 +++++++++++++
 tb/tb_pueo_pps_sec_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pueo_pps_sec_core.sv
// ============================================================================
// pueo_pps_sec_core : PPS source select (internal trimmed / external), seconds counter. Rev 1.0
// ============================================================================
`default_nettype none

module pueo_pps_sec_core #(
  parameter int unsigned NOMINAL_PERIOD = 125000000,
  parameter              SYSCLKTYPE     = "NONE"
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        ext_pps_i,
  input  logic        en_int_pps_i,
  input  logic        use_ext_pps_i,
  input  logic [15:0] pps_holdoff_i,
  input  logic [15:0] pps_trim_i,
  input  logic        update_pps_trim_i,
  input  logic [31:0] update_sec_i,
  input  logic        load_sec_i,
  output logic [15:0] pps_trim_o,
  output logic        pps_o,
  output logic [31:0] cur_sec_o,
  output logic [31:0] last_pps_o,
  output logic [31:0] llast_pps_o
);

  localparam logic signed [31:0] NOM_M1 = $signed(NOMINAL_PERIOD - 32'd1);

  logic [2:0]         ext_sync;
  logic               use_ext;
  logic               ext_edge;
  logic [31:0]        tstamp;
  logic [31:0]        count;
  logic [31:0]        holdoff_cnt;
  logic [31:0]        pend_val;
  logic               pending;
  logic signed [31:0] trim_ext;
  logic signed [31:0] thresh;
  logic               int_tick;
  logic               ext_accept;
  logic               pps_accept;

  // Cross-domain capture flops carry the CDC tag only when a clock type is named.
  if (SYSCLKTYPE == "NONE") begin : g_sync_plain
    logic [2:0] ext_q;
    logic       mode_q;
    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        ext_q  <= '0;
        mode_q <= 1'b0;
      end else begin
        ext_q  <= {ext_q[1:0], ext_pps_i};
        mode_q <= use_ext_pps_i;
      end
    end
    assign ext_sync = ext_q;
    assign use_ext  = mode_q;
  end else begin : g_sync_tagged
    (* CUSTOM_CC_DST = SYSCLKTYPE *) logic [1:0] ext_meta;
    (* CUSTOM_CC_DST = SYSCLKTYPE *) logic       mode_q;
    logic ext_prev;
    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
        ext_meta <= '0;
        ext_prev <= 1'b0;
        mode_q   <= 1'b0;
      end else begin
        ext_meta <= {ext_meta[0], ext_pps_i};
        ext_prev <= ext_meta[1];
        mode_q   <= use_ext_pps_i;
      end
    end
    assign ext_sync = {ext_prev, ext_meta};
    assign use_ext  = mode_q;
  end

  assign ext_edge   = ext_sync[1] & ~ext_sync[2];
  assign trim_ext   = {{16{pps_trim_o[15]}}, pps_trim_o};
  assign thresh     = NOM_M1 + trim_ext;
  // ">=" so a trim that drops the threshold below the running count fires at once.
  assign int_tick   = en_int_pps_i && ($signed(count) >= thresh);
  assign ext_accept = use_ext && ext_edge && (holdoff_cnt == 32'd0);
  assign pps_accept = use_ext ? ext_accept : int_tick;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tstamp      <= '0;
      count       <= '0;
      holdoff_cnt <= '0;
      pend_val    <= '0;
      pending     <= 1'b0;
      pps_trim_o  <= '0;
      pps_o       <= 1'b0;
      cur_sec_o   <= '0;
      last_pps_o  <= '0;
      llast_pps_o <= '0;
    end else begin
      tstamp <= tstamp + 32'd1;
      pps_o  <= pps_accept;

      if (update_pps_trim_i)
        pps_trim_o <= pps_trim_i;

      if (ext_accept || int_tick)
        count <= '0;
      else if (en_int_pps_i)
        count <= count + 32'd1;

      if (ext_accept)
        holdoff_cnt <= {pps_holdoff_i, 16'h0000};
      else if (holdoff_cnt != 32'd0)
        holdoff_cnt <= holdoff_cnt - 32'd1;

      if (load_sec_i)
        pend_val <= update_sec_i;

      if (pps_accept) begin
        last_pps_o  <= tstamp;
        llast_pps_o <= last_pps_o;
        pending     <= 1'b0;
        if (load_sec_i)
          cur_sec_o <= update_sec_i;
        else if (pending)
          cur_sec_o <= pend_val;
        else
          cur_sec_o <= cur_sec_o + 32'd1;
      end else if (load_sec_i) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pueo_pps_sec_core.sv
// ============================================================================
// tb_pueo_pps_sec_core : directed self-checking bench for pueo_pps_sec_core. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pueo_pps_sec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_pps;
  logic        en_int;
  logic        use_ext;
  logic [15:0] holdoff;
  logic [15:0] trim_in;
  logic        upd_trim;
  logic [31:0] upd_sec;
  logic        load_sec;
  logic [15:0] trim_out;
  logic        pps;
  logic [31:0] cur_sec;
  logic [31:0] last_pps;
  logic [31:0] llast_pps;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  pueo_pps_sec_core #(.NOMINAL_PERIOD(100), .SYSCLKTYPE("NONE")) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .ext_pps_i(ext_pps), .en_int_pps_i(en_int),
    .use_ext_pps_i(use_ext), .pps_holdoff_i(holdoff), .pps_trim_i(trim_in),
    .update_pps_trim_i(upd_trim), .update_sec_i(upd_sec), .load_sec_i(load_sec),
    .pps_trim_o(trim_out), .pps_o(pps), .cur_sec_o(cur_sec),
    .last_pps_o(last_pps), .llast_pps_o(llast_pps)
  );

  always #5 clk = ~clk;

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      if (pps) pulses++;
    end
  endtask

  task automatic wait_pps(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (pps) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic en, input logic ext_mode, input logic [15:0] ho);
    rst = 1'b1; ext_pps = 1'b0; upd_trim = 1'b0; trim_in = '0;
    load_sec = 1'b0; upd_sec = '0;
    en_int = en; use_ext = ext_mode; holdoff = ho;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_int = 1'b1; use_ext = 1'b0; ext_pps = 1'b0; holdoff = '0;
    trim_in = 16'h0007; upd_trim = 1'b1; upd_sec = 32'hDEADBEEF; load_sec = 1'b1;
    step(4);
    upd_trim = 1'b0; load_sec = 1'b0;
    total++; if (pps !== 1'b0) begin bad++; $display("FAIL reset_pps got=%b exp=0", pps); end
    total++; if (trim_out !== 16'h0) begin bad++; $display("FAIL reset_trim got=%h exp=0", trim_out); end
    total++; if (cur_sec !== 32'h0) begin bad++; $display("FAIL reset_cur_sec got=%h exp=0", cur_sec); end
    total++; if (last_pps !== 32'h0) begin bad++; $display("FAIL reset_last got=%h exp=0", last_pps); end
    total++; if (llast_pps !== 32'h0) begin bad++; $display("FAIL reset_llast got=%h exp=0", llast_pps); end
  endtask

  task automatic test_internal();
    int n;
    do_reset(1'b1, 1'b0, 16'h0);
    wait_pps(200, n);
    total++; if (n !== 100) begin bad++; $display("FAIL int_first_period got=%0d exp=100", n); end
    total++; if (last_pps !== 32'd99) begin bad++; $display("FAIL int_last1 got=%0d exp=99", last_pps); end
    total++; if (cur_sec !== 32'd1) begin bad++; $display("FAIL int_sec1 got=%0d exp=1", cur_sec); end
    step(1);
    total++; if (pps !== 1'b0) begin bad++; $display("FAIL int_pulse_width got=%b exp=0", pps); end
    wait_pps(200, n);
    total++; if (n !== 99) begin bad++; $display("FAIL int_second_period got=%0d exp=99", n); end
    total++; if (last_pps !== 32'd199) begin bad++; $display("FAIL int_last2 got=%0d exp=199", last_pps); end
    total++; if (llast_pps !== 32'd99) begin bad++; $display("FAIL int_llast2 got=%0d exp=99", llast_pps); end
    total++; if (cur_sec !== 32'd2) begin bad++; $display("FAIL int_sec2 got=%0d exp=2", cur_sec); end
  endtask

  task automatic test_trim();
    int n;
    do_reset(1'b1, 1'b0, 16'h0);
    trim_in = 16'd5; upd_trim = 1'b1;
    step(1);
    upd_trim = 1'b0;
    total++; if (trim_out !== 16'd5) begin bad++; $display("FAIL trim_load got=%h exp=0005", trim_out); end
    wait_pps(200, n);
    total++; if (n !== 104) begin bad++; $display("FAIL trim_p5_first got=%0d exp=104", n); end
    wait_pps(200, n);
    total++; if (n !== 105) begin bad++; $display("FAIL trim_p5_period got=%0d exp=105", n); end
    // count reaches 94 here; the -10 trim lands as it steps to 95
    step(94);
    trim_in = 16'hFFF6; upd_trim = 1'b1;
    step(1);
    upd_trim = 1'b0;
    total++; if (pps !== 1'b0) begin bad++; $display("FAIL trim_no_early_pulse got=%b exp=0", pps); end
    total++; if (trim_out !== 16'hFFF6) begin bad++; $display("FAIL trim_neg_load got=%h exp=fff6", trim_out); end
    wait_pps(200, n);
    total++; if (n !== 1) begin bad++; $display("FAIL trim_shorten_immediate got=%0d exp=1", n); end
    wait_pps(200, n);
    total++; if (n !== 90) begin bad++; $display("FAIL trim_m10_period got=%0d exp=90", n); end
  endtask

  task automatic test_ext();
    int n;
    do_reset(1'b1, 1'b1, 16'h0001);
    step(10);
    ext_pps = 1'b1;
    wait_pps(20, n);
    total++; if (n !== 3) begin bad++; $display("FAIL ext_latency1 got=%0d exp=3", n); end
    total++; if (last_pps !== 32'd12) begin bad++; $display("FAIL ext_last1 got=%0d exp=12", last_pps); end
    pulses = 0;
    step(2);      ext_pps = 1'b0;
    step(9995);   ext_pps = 1'b1;
    step(5);      ext_pps = 1'b0;
    step(60032);
    total++; if (pulses !== 0) begin bad++; $display("FAIL ext_holdoff_drop got=%0d pulses exp=0", pulses); end
    ext_pps = 1'b1;
    wait_pps(20, n);
    ext_pps = 1'b0; use_ext = 1'b0;
    total++; if (n !== 3) begin bad++; $display("FAIL ext_latency3 got=%0d exp=3", n); end
    total++; if (last_pps !== 32'd70049) begin bad++; $display("FAIL ext_last3 got=%0d exp=70049", last_pps); end
    total++; if (llast_pps !== 32'd12) begin bad++; $display("FAIL ext_llast3 got=%0d exp=12", llast_pps); end
    total++; if (cur_sec !== 32'd2) begin bad++; $display("FAIL ext_sec got=%0d exp=2", cur_sec); end
    wait_pps(200, n);
    total++; if (n !== 100) begin bad++; $display("FAIL ext_rephase got=%0d exp=100", n); end
  endtask

  task automatic test_sec_load();
    int n;
    do_reset(1'b1, 1'b0, 16'h0);
    upd_sec = 32'h12345678; load_sec = 1'b1;
    step(1);
    load_sec = 1'b0;
    wait_pps(200, n);
    total++; if (cur_sec !== 32'h12345678) begin bad++; $display("FAIL sec_load got=%h exp=12345678", cur_sec); end
    wait_pps(200, n);
    total++; if (cur_sec !== 32'h12345679) begin bad++; $display("FAIL sec_incr got=%h exp=12345679", cur_sec); end
    step(99);
    upd_sec = 32'hAAAA5555; load_sec = 1'b1;
    step(1);
    load_sec = 1'b0;
    total++; if (pps !== 1'b1) begin bad++; $display("FAIL sec_coinc_pps got=%b exp=1", pps); end
    total++; if (cur_sec !== 32'hAAAA5555) begin bad++; $display("FAIL sec_coinc_load got=%h exp=aaaa5555", cur_sec); end
    step(10);
    upd_sec = 32'h11111111; load_sec = 1'b1;
    step(1);
    upd_sec = 32'h22222222;
    step(1);
    load_sec = 1'b0;
    wait_pps(200, n);
    total++; if (cur_sec !== 32'h22222222) begin bad++; $display("FAIL sec_second_load got=%h exp=22222222", cur_sec); end
    wait_pps(200, n);
    total++; if (cur_sec !== 32'h22222223) begin bad++; $display("FAIL sec_pending_clear got=%h exp=22222223", cur_sec); end
    upd_sec = 32'hFFFFFFFF; load_sec = 1'b1;
    step(1);
    load_sec = 1'b0;
    wait_pps(200, n);
    total++; if (cur_sec !== 32'hFFFFFFFF) begin bad++; $display("FAIL sec_max got=%h exp=ffffffff", cur_sec); end
    wait_pps(200, n);
    total++; if (cur_sec !== 32'h0) begin bad++; $display("FAIL sec_wrap got=%h exp=0", cur_sec); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(1'b1, 1'b0, 16'h0);
    wait_pps(200, n);
    trim_in = 16'd3; upd_trim = 1'b1;
    step(1);
    upd_trim = 1'b0;
    step(49);
    rst = 1'b1; pulses = 0;
    step(1);
    total++; if (pps !== 1'b0) begin bad++; $display("FAIL mid_rst_pps got=%b exp=0", pps); end
    total++; if (cur_sec !== 32'h0) begin bad++; $display("FAIL mid_rst_sec got=%h exp=0", cur_sec); end
    total++; if (last_pps !== 32'h0) begin bad++; $display("FAIL mid_rst_last got=%h exp=0", last_pps); end
    total++; if (llast_pps !== 32'h0) begin bad++; $display("FAIL mid_rst_llast got=%h exp=0", llast_pps); end
    total++; if (trim_out !== 16'h0) begin bad++; $display("FAIL mid_rst_trim got=%h exp=0", trim_out); end
    step(120);
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_no_pulse got=%0d exp=0", pulses); end
    rst = 1'b0;
    wait_pps(200, n);
    total++; if (n !== 100) begin bad++; $display("FAIL mid_rst_first_pps got=%0d exp=100", n); end
    total++; if (cur_sec !== 32'd1) begin bad++; $display("FAIL mid_rst_sec_after got=%0d exp=1", cur_sec); end
  endtask

  initial begin
    rst = 1'b1; ext_pps = 1'b0; en_int = 1'b0; use_ext = 1'b0; holdoff = '0;
    trim_in = '0; upd_trim = 1'b0; upd_sec = '0; load_sec = 1'b0;
    test_reset();
    test_internal();
    test_trim();
    test_ext();
    test_sec_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
